// File: rtl/mult_pipe_pkg.sv
// Shared types and helpers for the pipelined Booth radix-4 multiplier.
// The accumulator option (MULT_PIPE_ACC_EN) is handled in the top; nothing here depends on it.
package mult_pipe_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned NPP       = (WIDTH_DEF + 2) / 2;
    localparam int unsigned PW        = 2 * WIDTH_DEF;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_P1   = 3'd1,
        BD_P2   = 3'd2,
        BD_M1   = 3'd3,
        BD_M2   = 3'd4
    } booth_digit_t;

    // Radix-4 digit from the overlapping triplet {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_digit_t booth_recode(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: booth_recode = BD_P1;
            3'b011:         booth_recode = BD_P2;
            3'b100:         booth_recode = BD_M2;
            3'b101, 3'b110: booth_recode = BD_M1;
            default:        booth_recode = BD_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/mult_booth4_core.sv
// Combinational Booth radix-4 multiplier: partial products, carry-save reduction, Kogge-Stone adder.
// Operands are widened by two bits so one recoding scheme covers signed and unsigned modes.
module mult_booth4_core
    import mult_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               tc_i,
    output logic [2*WIDTH-1:0] prod_c
);

    localparam int unsigned EW     = WIDTH + 2;
    localparam int unsigned OW     = 2 * WIDTH;
    localparam int unsigned NUM_PP = EW / 2;
    localparam int unsigned LVLS   = $clog2(OW);

    logic [EW-1:0] a_ext;
    logic [EW-1:0] b_ext;
    logic [EW:0]   b_win;
    logic [OW-1:0] a_wide;
    logic [OW-1:0] csa_s;
    logic [OW-1:0] csa_c;

    assign a_ext  = tc_i ? {{2{a_i[WIDTH-1]}}, a_i} : {2'b00, a_i};
    assign b_ext  = tc_i ? {{2{b_i[WIDTH-1]}}, b_i} : {2'b00, b_i};
    assign b_win  = {b_ext, 1'b0};
    assign a_wide = {{(OW-EW){a_ext[EW-1]}}, a_ext};

    // Partial products folded into a redundant sum/carry pair, modulo 2^OW
    always_comb begin
        logic [OW-1:0] pp;
        logic [OW-1:0] s_n;
        logic [OW-1:0] c_n;
        csa_s = '0;
        csa_c = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            case (booth_recode(b_win[2*i +: 3]))
                BD_P1:   pp = a_wide;
                BD_P2:   pp = a_wide << 1;
                BD_M1:   pp = ~a_wide + OW'(1);
                BD_M2:   pp = ~(a_wide << 1) + OW'(1);
                default: pp = '0;
            endcase
            pp    = pp << (2*i);
            s_n   = csa_s ^ csa_c ^ pp;
            c_n   = ((csa_s & csa_c) | (csa_s & pp) | (csa_c & pp)) << 1;
            csa_s = s_n;
            csa_c = c_n;
        end
    end

    // Kogge-Stone parallel prefix carry resolution
    always_comb begin
        logic [OW-1:0] g;
        logic [OW-1:0] p;
        logic [OW-1:0] g_n;
        logic [OW-1:0] p_n;
        g = csa_s & csa_c;
        p = csa_s ^ csa_c;
        for (int l = 0; l < LVLS; l++) begin
            g_n = g;
            p_n = p;
            for (int i = (1 << l); i < OW; i++) begin
                g_n[i] = g[i] | (p[i] & g[i - (1 << l)]);
                p_n[i] = p[i] & p[i - (1 << l)];
            end
            g = g_n;
            p = p_n;
        end
        prod_c = (csa_s ^ csa_c) ^ {g[OW-2:0], 1'b0};
    end

endmodule

// File: rtl/mult_booth4_pipe.sv
// Pipelined Booth radix-4 multiplier with valid/ready flow control and a global stall.
// Define MULT_PIPE_ACC_EN to add the running accumulator (acc_clr / acc_out).
module mult_booth4_pipe
    import mult_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned STAGES = 3
`ifdef MULT_PIPE_ACC_EN
    ,
    parameter int unsigned GUARD  = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_tc,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
`ifdef MULT_PIPE_ACC_EN
    input  logic                 acc_clr,
    output logic [2*WIDTH+GUARD-1:0] acc_out,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW_L  = 2 * WIDTH;
    localparam int unsigned NPC   = STAGES - 2;
    localparam int unsigned NPC_A = (NPC == 0) ? 1 : NPC;
`ifdef MULT_PIPE_ACC_EN
    localparam int unsigned PAY_W = PW_L + 2;
    localparam int unsigned ACC_W = PW_L + GUARD;
`else
    localparam int unsigned PAY_W = PW_L;
`endif

    logic             stall_c;
    logic             in_v_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             tc_q;
    logic [PW_L-1:0]  core_prod_c;
    logic [PAY_W-1:0] core_pay_c;
    logic             pc_v_q   [NPC_A];
    logic [PAY_W-1:0] pc_pay_q [NPC_A];
    logic             out_src_v;
    logic [PAY_W-1:0] out_src_pay;
    logic             out_valid_q, out_valid_d;
    logic [PW_L-1:0]  product_q, product_d;

    assign stall_c  = out_valid_q & ~out_ready;
    assign in_ready = ~stall_c;

    // Operand capture; data regs only move for a real transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_v_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            tc_q   <= 1'b0;
        end else if (!stall_c) begin
            in_v_q <= in_valid;
            if (in_valid) begin
                a_q  <= multiplicand;
                b_q  <= multiplier;
                tc_q <= in_tc;
            end
        end
    end

    mult_booth4_core #(.WIDTH(WIDTH)) u_core (
        .a_i    (a_q),
        .b_i    (b_q),
        .tc_i   (tc_q),
        .prod_c (core_prod_c)
    );

`ifdef MULT_PIPE_ACC_EN
    logic clr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_q <= 1'b0;
        end else if (!stall_c && in_valid) begin
            clr_q <= acc_clr;
        end
    end

    assign core_pay_c = {clr_q, tc_q, core_prod_c};
`else
    assign core_pay_c = core_prod_c;
`endif

    // Retiming chain after the core; mode/clear bits ride along with the product
    for (genvar k = 0; k < NPC; k++) begin : g_post
        logic             src_v;
        logic [PAY_W-1:0] src_pay;
        if (k == 0) begin : g_first
            assign src_v   = in_v_q;
            assign src_pay = core_pay_c;
        end else begin : g_next
            assign src_v   = pc_v_q[k-1];
            assign src_pay = pc_pay_q[k-1];
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pc_v_q[k]   <= 1'b0;
                pc_pay_q[k] <= '0;
            end else if (!stall_c) begin
                pc_v_q[k] <= src_v;
                if (src_v) begin
                    pc_pay_q[k] <= src_pay;
                end
            end
        end
    end

    if (NPC == 0) begin : g_direct
        assign out_src_v   = in_v_q;
        assign out_src_pay = core_pay_c;
    end else begin : g_chain
        assign out_src_v   = pc_v_q[NPC-1];
        assign out_src_pay = pc_pay_q[NPC-1];
    end

`ifdef MULT_PIPE_ACC_EN
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] acc_ext_c;

    assign acc_ext_c = out_src_pay[PW_L] ? {{GUARD{out_src_pay[PW_L-1]}}, out_src_pay[PW_L-1:0]}
                                         : {{GUARD{1'b0}}, out_src_pay[PW_L-1:0]};
`endif

    // Output stage next state
    always_comb begin
        out_valid_d = out_valid_q;
        product_d   = product_q;
`ifdef MULT_PIPE_ACC_EN
        acc_d       = acc_q;
`endif
        if (!stall_c) begin
            out_valid_d = out_src_v;
            if (out_src_v) begin
                product_d = out_src_pay[PW_L-1:0];
`ifdef MULT_PIPE_ACC_EN
                acc_d     = (out_src_pay[PW_L+1] ? '0 : acc_q) + acc_ext_c;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            product_q   <= '0;
`ifdef MULT_PIPE_ACC_EN
            acc_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
`ifdef MULT_PIPE_ACC_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign product   = product_q;
`ifdef MULT_PIPE_ACC_EN
    assign acc_out   = acc_q;
`endif

endmodule

// File: tb/tb_mult_booth4_pipe.sv
// Self-checking bench for mult_booth4_pipe against a queue-based arithmetic reference.
// Accumulator checks are compiled in when MULT_PIPE_ACC_EN is defined.
module tb_mult_booth4_pipe;

    localparam int unsigned W   = 16;
    localparam int unsigned ST  = 3;
    localparam int unsigned G   = 8;
    localparam int unsigned PWT = 2 * W;
    localparam int unsigned AW  = PWT + G;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           in_tc;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic           out_valid;
    logic           out_ready;
    logic [PWT-1:0] product;
`ifdef MULT_PIPE_ACC_EN
    logic           acc_clr;
    logic [AW-1:0]  acc_out;
    logic [AW-1:0]  obs_acc[$];
`endif

    typedef struct {
        logic [PWT-1:0] prod;
        logic [AW-1:0]  acc;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] acc_m;
    int            n_chk = 0;
    int            n_err = 0;
    int            n_out = 0;
    int            n_valid_seen = 0;

    always #5 clk = ~clk;

    mult_booth4_pipe #(
        .WIDTH  (W),
        .STAGES (ST)
`ifdef MULT_PIPE_ACC_EN
        ,
        .GUARD  (G)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_tc        (in_tc),
        .multiplicand (mcand),
        .multiplier   (mplier),
`ifdef MULT_PIPE_ACC_EN
        .acc_clr      (acc_clr),
        .acc_out      (acc_out),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PWT-1:0] ref_mul(input logic tc, input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        if (tc) p = longint'($signed(a)) * longint'($signed(b));
        else    p = longint'(a) * longint'(b);
        return p[PWT-1:0];
    endfunction

    // One clock: drive at negedge, then score what the next rising edge will transfer
    task automatic cycle(input logic v, input logic tc, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic clr, input logic ordy, output logic taken);
        logic [PWT-1:0] p;
        @(negedge clk);
        in_valid  = v;
        in_tc     = tc;
        mcand     = a;
        mplier    = b;
        out_ready = ordy;
`ifdef MULT_PIPE_ACC_EN
        acc_clr   = clr;
`endif
        #1;
        taken = 1'b0;
        if (!rst) begin
            check("in_ready", 64'(in_ready), 64'(!(out_valid && !ordy)));
            if (out_valid) begin
                n_valid_seen++;
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    if (ordy) check("product", 64'(product), 64'(exp_q[0].prod));
                    else      check("stable_product", 64'(product), 64'(exp_q[0].prod));
`ifdef MULT_PIPE_ACC_EN
                    check("acc_out", 64'(acc_out), 64'(exp_q[0].acc));
                    if (ordy) obs_acc.push_back(acc_out);
`endif
                    if (ordy) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (v && in_ready) begin
                taken = 1'b1;
                p     = ref_mul(tc, a, b);
                acc_m = (clr ? '0 : acc_m) + (tc ? {{G{p[PWT-1]}}, p} : {{G{1'b0}}, p});
                exp_q.push_back('{prod: p, acc: acc_m});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic         t;
        int           lat;
        int           base;
        int           c;
        int           sent;
        int           stalls;
        int           seen;
        logic [W-1:0] ra, rb;
        logic         rtc;

        rst = 1'b1; in_valid = 1'b0; in_tc = 1'b0; mcand = '0; mplier = '0; out_ready = 1'b1;
`ifdef MULT_PIPE_ACC_EN
        acc_clr = 1'b0;
`endif
        acc_m = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_product", 64'(product), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
`ifdef MULT_PIPE_ACC_EN
        check("rst_acc_out", 64'(acc_out), 64'(0));
`endif
        @(negedge clk);
        rst = 1'b0;

        // Latency: count cycles from the accepting cycle to the first valid output cycle
        cycle(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b1, 1'b1, t);
        check("lat_accept", 64'(t), 64'(1));
        lat = 0;
        do begin
            cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, t);
            lat++;
        end while (!out_valid && lat < 20);
        check("latency", 64'(lat), 64'(ST));
        check("lat_product", 64'(product), 64'h4000_0000);

        // Mixed modes back to back
        cycle(1'b1, 1'b1, 16'hFFFF, 16'h0002, 1'b1, 1'b1, t);
        cycle(1'b1, 1'b0, 16'hFFFF, 16'h0002, 1'b0, 1'b1, t);
        lat = 0;
        do begin
            cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, t);
            lat++;
        end while (!out_valid && lat < 20);
        check("mode_signed", 64'(product), 64'hFFFF_FFFE);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, t);
        check("mode_uns_valid", 64'(out_valid), 64'(1));
        check("mode_unsigned", 64'(product), 64'h0001_FFFE);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, t);

        // Backpressure: out_ready 1-0-0 repeating, operands held until accepted
        base = n_out; sent = 0; c = 0;
        ra = W'($urandom); rb = W'($urandom); rtc = 1'($urandom_range(0, 1));
        while (sent < 8 && c < 200) begin
            cycle(1'b1, rtc, ra, rb, 1'b0, (c % 3) == 0, t);
            c++;
            if (t) begin
                sent++;
                ra = W'($urandom); rb = W'($urandom); rtc = 1'($urandom_range(0, 1));
            end
        end
        while (exp_q.size() > 0 && c < 300) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b0, (c % 3) == 0, t);
            c++;
        end
        check("bp_count", 64'(n_out - base), 64'(8));
        check("bp_drained", 64'(exp_q.size()), 64'(0));

        // Full throughput, both modes
        base = n_out; stalls = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                  $urandom_range(0, 7) == 0, 1'b1, t);
            if (!t) stalls++;
        end
        repeat (ST) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, t);
        check("tp_no_stall", 64'(stalls), 64'(0));
        check("tp_count", 64'(n_out - base), 64'(1000));
        check("tp_drained", 64'(exp_q.size()), 64'(0));

`ifdef MULT_PIPE_ACC_EN
        obs_acc.delete();
        cycle(1'b1, 1'b1, 16'd3, 16'd4, 1'b1, 1'b1, t);
        cycle(1'b1, 1'b1, 16'hFFFE, 16'd5, 1'b0, 1'b1, t);
        cycle(1'b1, 1'b1, 16'd7, 16'd1, 1'b0, 1'b1, t);
        cycle(1'b1, 1'b1, 16'd1, 16'd1, 1'b1, 1'b1, t);
        repeat (ST + 1) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, t);
        check("acc_n", 64'(obs_acc.size()), 64'(4));
        if (obs_acc.size() == 4) begin
            check("acc_first", 64'(obs_acc[0]), 64'd12);
            check("acc_second", 64'(obs_acc[1]), 64'd2);
            check("acc_third", 64'(obs_acc[2]), 64'd9);
            check("acc_cleared", 64'(obs_acc[3]), 64'd1);
        end
`endif

        // Reset with three pairs in flight
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'b0, 1'b1, t);
        end
        @(posedge clk);
        #2;
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_product", 64'(product), 64'(0));
`ifdef MULT_PIPE_ACC_EN
        check("midrst_acc_out", 64'(acc_out), 64'(0));
`endif
        exp_q.delete();
        acc_m = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = n_valid_seen;
        repeat (8) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, t);
        check("post_rst_quiet", 64'(n_valid_seen - seen), 64'(0));
        check("post_rst_ready", 64'(in_ready), 64'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
